// File: rtl/oled_source_arbiter.sv
// oled_source_arbiter
//   Selects which screen (menu or board) feeds the OLED driver and inserts
//   BLANK_FRAMES full frames of BLANK_COLOR whenever the displayed screen
//   changes. Screen changes are only evaluated on frame_begin pulses.
//
// Ports
//   clock        6.25 MHz OLED pixel clock
//   reset_n      asynchronous active-low reset
//   start        screen request level (0 = menu, 1 = board)
//   frame_begin  one-cycle pulse marking the start of a frame
//   pixel_index  current pixel, 0-6143, row-major over 96x64
//   pix_menu     menu-screen RGB565 pixel for pixel_index
//   pix_board    board-screen RGB565 pixel for pixel_index
//   pixel_data   registered pixel to the OLED driver
//   src_board    1 while the board screen is displayed
//   switching    1 while blank frames are being inserted
//
// Build option
//   OLED_BORDER_EN  when defined, the outer ring of pixels shows BORDER_COLOR
//                   while the board screen is displayed.
module oled_source_arbiter #(
  parameter int unsigned BLANK_FRAMES = 2,
  parameter logic [15:0] BLANK_COLOR  = 16'h0000,
  parameter logic [15:0] BORDER_COLOR = 16'hFFFF
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic        frame_begin,
  input  logic [12:0] pixel_index,
  input  logic [15:0] pix_menu,
  input  logic [15:0] pix_board,
  output logic [15:0] pixel_data,
  output logic        src_board,
  output logic        switching
);

  typedef enum logic [1:0] {
    MENU           = 2'd0,
    BLANK_TO_BOARD = 2'd1,
    BOARD          = 2'd2,
    BLANK_TO_MENU  = 2'd3
  } state_t;

  localparam logic [3:0]  BLANK_N   = 4'(BLANK_FRAMES);
  localparam logic [12:0] LAST_PIX  = 13'd6143;

  state_t      state, state_nx;
  logic [3:0]  cnt, cnt_nx;
  logic [15:0] pix_nx;
  logic        in_range;
  logic        on_border;

  // Next-state / blank-frame counter. Only frame_begin cycles can move.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    if (frame_begin) begin
      case (state)
        MENU: begin
          if (start) begin
            if (BLANK_N == 4'd0) begin
              state_nx = BOARD;
            end else begin
              state_nx = BLANK_TO_BOARD;
              cnt_nx   = BLANK_N;
            end
          end
        end
        BLANK_TO_BOARD: begin
          if (start) begin
            // Counter at 1 means the last blank frame has just completed.
            if (cnt <= 4'd1) begin
              state_nx = BOARD;
              cnt_nx   = '0;
            end else begin
              cnt_nx = cnt - 4'd1;
            end
          end else begin
            state_nx = MENU;
            cnt_nx   = '0;
          end
        end
        BOARD: begin
          if (!start) begin
            if (BLANK_N == 4'd0) begin
              state_nx = MENU;
            end else begin
              state_nx = BLANK_TO_MENU;
              cnt_nx   = BLANK_N;
            end
          end
        end
        BLANK_TO_MENU: begin
          if (!start) begin
            if (cnt <= 4'd1) begin
              state_nx = MENU;
              cnt_nx   = '0;
            end else begin
              cnt_nx = cnt - 4'd1;
            end
          end else begin
            state_nx = BOARD;
            cnt_nx   = '0;
          end
        end
      endcase
    end
  end

  assign in_range = (pixel_index <= LAST_PIX);

`ifdef OLED_BORDER_EN
  logic [12:0] col;
  assign col       = pixel_index % 13'd96;
  assign on_border = (col == 13'd0) || (col == 13'd95) ||
                     (pixel_index < 13'd96) || (pixel_index >= 13'd6048);
`else
  assign on_border = 1'b0;
`endif

  // Output pixel follows the state being entered on this edge.
  always_comb begin
    pix_nx = BLANK_COLOR;
    if (in_range) begin
      case (state_nx)
        MENU:    pix_nx = pix_menu;
        BOARD:   pix_nx = on_border ? BORDER_COLOR : pix_board;
        default: pix_nx = BLANK_COLOR;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= MENU;
      cnt        <= '0;
      pixel_data <= 16'h0000;
      src_board  <= 1'b0;
      switching  <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      pixel_data <= pix_nx;
      src_board  <= (state_nx == BOARD);
      switching  <= (state_nx == BLANK_TO_BOARD) || (state_nx == BLANK_TO_MENU);
    end
  end

endmodule

// File: tb/tb_oled_source_arbiter.sv
module tb_oled_source_arbiter;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic        frame_begin;
  logic [12:0] pixel_index;
  logic [15:0] pix_menu;
  logic [15:0] pix_board;

  logic [15:0] pd0, pd1;
  logic        src0, src1, sw0, sw1;

  int n_checks = 0;
  int n_fail   = 0;
  bit border_mode = 1'b0;
  bit started = 1'b0;
  bit sw1_seen = 1'b0;

  always #5 clock = ~clock;

  oled_source_arbiter dut0 (
    .clock(clock), .reset_n(reset_n), .start(start), .frame_begin(frame_begin),
    .pixel_index(pixel_index), .pix_menu(pix_menu), .pix_board(pix_board),
    .pixel_data(pd0), .src_board(src0), .switching(sw0)
  );

  oled_source_arbiter #(.BLANK_FRAMES(0)) dut1 (
    .clock(clock), .reset_n(reset_n), .start(start), .frame_begin(frame_begin),
    .pixel_index(pixel_index), .pix_menu(pix_menu), .pix_board(pix_board),
    .pixel_data(pd1), .src_board(src1), .switching(sw1)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Per instance: which screen is shown (0 menu, 1 board) and how many
  // blank frames are still owed before the other screen appears.
  int unsigned nblank [2] = '{2, 0};
  int          shown  [2] = '{0, 0};
  int          left   [2] = '{0, 0};
  logic [15:0] exp_pd [2] = '{16'h0000, 16'h0000};
  bit          exp_src[2] = '{1'b0, 1'b0};
  bit          exp_sw [2] = '{1'b0, 1'b0};

  function automatic logic [15:0] model_pix(input bit blank, input bit board,
                                            input logic [12:0] i,
                                            input logic [15:0] pm, input logic [15:0] pb);
    int ii;
    ii = int'(i);
    if (ii > 6143 || blank) return 16'h0000;
    if (!board) return pm;
`ifdef OLED_BORDER_EN
    if ((ii % 96) == 0 || (ii % 96) == 95 || (ii / 96) == 0 || (ii / 96) == 63)
      return 16'hFFFF;
`endif
    return pb;
  endfunction

  always @(posedge clock or negedge reset_n) begin
    for (int k = 0; k < 2; k++) begin
      if (!reset_n) begin
        shown[k] = 0; left[k] = 0;
        exp_pd[k] = 16'h0000; exp_src[k] = 1'b0; exp_sw[k] = 1'b0;
      end else begin
        if (frame_begin) begin
          if (left[k] > 0) begin
            if (int'(start) != shown[k]) begin
              if (left[k] == 1) begin shown[k] = 1 - shown[k]; left[k] = 0; end
              else left[k] = left[k] - 1;
            end else begin
              left[k] = 0;
            end
          end else if (int'(start) != shown[k]) begin
            if (nblank[k] == 0) shown[k] = int'(start);
            else left[k] = int'(nblank[k]);
          end
        end
        exp_sw[k]  = (left[k] > 0);
        exp_src[k] = (left[k] == 0) && (shown[k] == 1);
        exp_pd[k]  = model_pix(exp_sw[k], shown[k] == 1, pixel_index, pix_menu, pix_board);
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clock) begin
    if (started) begin
      chk("m_pd0",  {16'h0, pd0}, {16'h0, exp_pd[0]});
      chk("m_src0", {31'h0, src0}, {31'h0, exp_src[0]});
      chk("m_sw0",  {31'h0, sw0}, {31'h0, exp_sw[0]});
      chk("m_pd1",  {16'h0, pd1}, {16'h0, exp_pd[1]});
      chk("m_src1", {31'h0, src1}, {31'h0, exp_src[1]});
      chk("m_sw1",  {31'h0, sw1}, {31'h0, exp_sw[1]});
      if (sw1) sw1_seen = 1'b1;
    end
  end

  // ---------------- stimulus ----------------
  logic [12:0] idx_tab [12] = '{13'd0, 13'd1, 13'd95, 13'd96, 13'd100, 13'd6047,
                                13'd6048, 13'd6143, 13'd6144, 13'd6200, 13'd8191, 13'd3000};
  int tab_pos = 0;

  task automatic tick(input bit s, input bit fb, input logic [12:0] i);
    @(negedge clock);
    start       = s;
    frame_begin = fb;
    pixel_index = i;
    pix_menu    = {3'b000, i} ^ 16'hA000;
    pix_board   = border_mode ? 16'h1234 : ({3'b000, i} ^ 16'h5000);
  endtask

  task automatic run(input bit s, input int n);
    for (int j = 0; j < n; j++) begin
      tick(s, 1'b0, idx_tab[tab_pos]);
      tab_pos = (tab_pos + 1) % 12;
    end
  endtask

  task automatic post;
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; frame_begin = 1'b0;
    pixel_index = '0; pix_menu = '0; pix_board = '0;
    started = 1'b1;
    repeat (3) @(negedge clock);
    chk("rst_pd",  {16'h0, pd0}, 32'h0);
    chk("rst_src", {31'h0, src0}, 32'h0);
    chk("rst_sw",  {31'h0, sw0}, 32'h0);

    @(negedge clock); reset_n = 1'b1;
    run(1'b1, 4); post;
    chk("no_move_before_fb_src1", {31'h0, src1}, 32'h0);
    chk("no_move_before_fb_sw0",  {31'h0, sw0}, 32'h0);

    // Menu -> board, two blank frames on dut0, direct on dut1
    tick(1'b1, 1'b1, 13'd100); post;
    chk("p1_sw0",  {31'h0, sw0}, 32'h1);
    chk("p1_pd0",  {16'h0, pd0}, 32'h0);
    chk("n0_src1", {31'h0, src1}, 32'h1);
    chk("n0_pd1",  {16'h0, pd1}, 32'h5064);
    run(1'b0, 3); run(1'b1, 3);
    tick(1'b1, 1'b1, 13'd100); post;
    chk("p2_sw0", {31'h0, sw0}, 32'h1);
    chk("p2_pd0", {16'h0, pd0}, 32'h0);
    run(1'b1, 5);
    tick(1'b1, 1'b1, 13'd100); post;
    chk("p3_src0", {31'h0, src0}, 32'h1);
    chk("p3_pd0",  {16'h0, pd0}, 32'h5064);
    chk("p3_sw0",  {31'h0, sw0}, 32'h0);

    // Abort board -> menu switch
    tick(1'b0, 1'b1, 13'd100); post;
    chk("ab_sw0",  {31'h0, sw0}, 32'h1);
    chk("ab_src1", {31'h0, src1}, 32'h0);
    chk("ab_pd1",  {16'h0, pd1}, 32'hA064);
    run(1'b1, 3);
    tick(1'b1, 1'b1, 13'd100); post;
    chk("ab_back_src0", {31'h0, src0}, 32'h1);
    chk("ab_back_sw0",  {31'h0, sw0}, 32'h0);
    chk("ab_back_pd0",  {16'h0, pd0}, 32'h5064);

    // Full board -> menu switch after abort takes two full blank frames
    tick(1'b0, 1'b1, 13'd100); post;
    chk("bm1_sw0", {31'h0, sw0}, 32'h1);
    run(1'b0, 2);
    tick(1'b0, 1'b1, 13'd100); post;
    chk("bm2_sw0", {31'h0, sw0}, 32'h1);
    run(1'b0, 2);
    tick(1'b0, 1'b1, 13'd100); post;
    chk("bm3_src0", {31'h0, src0}, 32'h0);
    chk("bm3_sw0",  {31'h0, sw0}, 32'h0);
    chk("bm3_pd0",  {16'h0, pd0}, 32'hA064);

    // Asynchronous reset mid-switch
    tick(1'b1, 1'b1, 13'd100); post;
    chk("mr_sw0", {31'h0, sw0}, 32'h1);
    run(1'b1, 2);
    @(posedge clock); #2;
    reset_n = 1'b0; #1;
    chk("ar_pd0",  {16'h0, pd0}, 32'h0);
    chk("ar_src0", {31'h0, src0}, 32'h0);
    chk("ar_sw0",  {31'h0, sw0}, 32'h0);
    chk("ar_pd1",  {16'h0, pd1}, 32'h0);
    chk("ar_src1", {31'h0, src1}, 32'h0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    run(1'b1, 3);
    tick(1'b1, 1'b0, 13'd100); post;
    chk("ar_stay_pd0", {16'h0, pd0}, 32'hA064);
    chk("ar_stay_sw0", {31'h0, sw0}, 32'h0);
    tick(1'b1, 1'b1, 13'd100); post;
    chk("ar_go_sw0", {31'h0, sw0}, 32'h1);
    run(1'b1, 2);
    tick(1'b1, 1'b1, 13'd100);
    run(1'b1, 2);
    tick(1'b1, 1'b1, 13'd3000); post;
    chk("ar_board_src0", {31'h0, src0}, 32'h1);
    chk("ar_board_pd0",  {16'h0, pd0}, 32'h5BB8);

    // Out-of-range pixels blank even in BOARD
    tick(1'b1, 1'b0, 13'd6144); post;
    chk("oor6144", {16'h0, pd0}, 32'h0);
    tick(1'b1, 1'b0, 13'd8191); post;
    chk("oor8191", {16'h0, pd0}, 32'h0);
    tick(1'b1, 1'b0, 13'd6143); post;
`ifdef OLED_BORDER_EN
    chk("last_pix", {16'h0, pd0}, 32'hFFFF);
`else
    chk("last_pix", {16'h0, pd0}, 32'h47FF);
`endif

    // Border ring
    border_mode = 1'b1;
`ifdef OLED_BORDER_EN
    tick(1'b1, 1'b0, 13'd0);    post; chk("bd_0",    {16'h0, pd0}, 32'hFFFF);
    tick(1'b1, 1'b0, 13'd95);   post; chk("bd_95",   {16'h0, pd0}, 32'hFFFF);
    tick(1'b1, 1'b0, 13'd6048); post; chk("bd_6048", {16'h0, pd0}, 32'hFFFF);
    tick(1'b1, 1'b0, 13'd100);  post; chk("bd_100",  {16'h0, pd0}, 32'h1234);
`else
    tick(1'b1, 1'b0, 13'd0);    post; chk("bd_0",    {16'h0, pd0}, 32'h1234);
    tick(1'b1, 1'b0, 13'd95);   post; chk("bd_95",   {16'h0, pd0}, 32'h1234);
    tick(1'b1, 1'b0, 13'd6048); post; chk("bd_6048", {16'h0, pd0}, 32'h1234);
    tick(1'b1, 1'b0, 13'd100);  post; chk("bd_100",  {16'h0, pd0}, 32'h1234);
`endif
    tick(1'b1, 1'b0, 13'd6200); post; chk("bd_6200", {16'h0, pd0}, 32'h0);
    border_mode = 1'b0;
    run(1'b1, 2);
    @(negedge clock);

    chk("n0_never_switch", {31'h0, sw1_seen}, 32'h0);
    started = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/oled_source_arbiter.md
OLED_SOURCE_ARBITER -- requirements
Module: oled_source_arbiter

Interface
REQ-001 The block SHALL have parameter BLANK_FRAMES, default 2, meaning the number of full blank frames inserted on every screen switch (legal range 0-15).
REQ-002 The block SHALL have parameter BLANK_COLOR, default 16'h0000, meaning the RGB565 value driven during blank frames.
REQ-003 The block SHALL have parameter BORDER_COLOR, default 16'hFFFF, meaning the RGB565 border value used only when OLED_BORDER_EN is defined.
REQ-004 clock  input  1  single clock, the 6.25 MHz OLED pixel clock; all state changes on its rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  screen request level; 0 = menu, 1 = board.
REQ-007 frame_begin  input  1  one-cycle pulse from the OLED driver marking the start of a frame.
REQ-008 pixel_index  input  13  current pixel, 0-6143, row-major over 96x64.
REQ-009 pix_menu  input  16  menu-screen RGB565 pixel for pixel_index.
REQ-010 pix_board  input  16  board-screen RGB565 pixel for pixel_index.
REQ-011 pixel_data  output  16  registered pixel delivered to the OLED driver.
REQ-012 src_board  output  1  1 while the board screen is the displayed source.
REQ-013 switching  output  1  1 while blank frames are being inserted.

Function
REQ-014 The block SHALL implement states MENU, BLANK_TO_BOARD, BOARD, BLANK_TO_MENU.
REQ-015 Transitions SHALL be evaluated only in cycles where frame_begin=1; start changes between pulses SHALL have no effect until the next pulse.
REQ-016 MENU with start=1 at frame_begin SHALL go to BLANK_TO_BOARD and load the frame counter with BLANK_FRAMES; with BLANK_FRAMES=0 it SHALL go directly to BOARD.
REQ-017 BOARD with start=0 at frame_begin SHALL go to BLANK_TO_MENU symmetrically, or directly to MENU when BLANK_FRAMES=0.
REQ-018 In a BLANK state, at frame_begin: if start still requests the destination, decrement the counter, and at counter=1 enter the destination state instead of decrementing.
REQ-019 In a BLANK state, at frame_begin with start requesting the origin screen, the block SHALL return directly to the origin state, clearing the counter.
REQ-020 pixel_data SHALL update every cycle with one-cycle latency: pix_menu in MENU, pix_board in BOARD, BLANK_COLOR in BLANK states, using the state value after the current edge's transition.
REQ-021 src_board SHALL be 1 exactly in BOARD; switching SHALL be 1 exactly in BLANK_TO_BOARD and BLANK_TO_MENU.
REQ-022 pixel_index values above 6143 SHALL cause BLANK_COLOR output regardless of state.
REQ-023 The block SHALL hold exactly BLANK_FRAMES complete frames of BLANK_COLOR between the last origin frame and the first destination frame in an uninterrupted switch.

Reset
REQ-024 Assertion of reset_n=0 SHALL immediately force state MENU, counter 0, pixel_data 16'h0000, src_board 0, switching 0, including mid-switch.
REQ-025 After reset_n deasserts, the first transition SHALL occur no earlier than the first frame_begin pulse.

Configuration
REQ-026 With macro OLED_BORDER_EN defined, pixels in column 0, column 95, row 0 or row 63 SHALL output BORDER_COLOR while in BOARD; other states are unaffected.
REQ-027 Without OLED_BORDER_EN, no border logic SHALL be synthesised and BOARD output SHALL equal pix_board for all in-range pixels.

Verification
REQ-028 Reset, start=1, then frame_begin pulses 1,2,3 with BLANK_FRAMES=2 -> switching=1 after pulse 1; pixel_data=0000 during frames 1-2; src_board=1 and pixel_data=pix_board after pulse 3.
REQ-029 In BOARD, start=0 then frame_begin -> BLANK_TO_MENU; start=1 before next pulse -> state BOARD at that pulse; counter cleared.
REQ-030 BLANK_FRAMES=0, in MENU, start=1 and frame_begin -> src_board=1 and pixel_data=pix_board one cycle later; switching never asserts.
REQ-031 reset_n pulsed low during BLANK_TO_BOARD -> pixel_data=0000, src_board=0, switching=0 without a clock edge; stays MENU until next frame_begin with start=1.
REQ-032 OLED_BORDER_EN defined, BOARD, pix_board=1234: pixel_index 0, 95, 6048, 100 -> FFFF, FFFF, FFFF, 1234; pixel_index 6200 -> 0000.
